// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory port arbiter: FSM states, grant codes,
// access field widths and the latched access record.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DMA_ACC = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } grant_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_acc_t;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; term_o flags the saturation value.
module sat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 8,
    parameter int WIDTH = cnt_width(LIMIT)
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic en_i,
    input  logic clr_i,
    output logic term_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != WIDTH'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == WIDTH'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (CPU priority, DMA anti-starvation) arbiter for a single memory port,
// with per-access ack timeout reported as a bus error alongside Ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCpuReq,
    input  logic        iCpuWe,
    input  logic [31:0] iCpuAddr,
    input  logic [31:0] iCpuWData,
    input  logic [3:0]  iCpuByteEn,
    output logic        oCpuReady,
    output logic [31:0] oCpuRData,
    input  logic        iDmaReq,
    input  logic        iDmaWe,
    input  logic [31:0] iDmaAddr,
    input  logic [31:0] iDmaWData,
    input  logic [3:0]  iDmaByteEn,
    output logic        oDmaReady,
    output logic [31:0] oDmaRData,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemByteEn,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output logic        oBusErr,
    output logic [1:0]  oGrant
);

    localparam int WAIT_W = cnt_width(STARVE_LIMIT);
    localparam int TMO_W  = cnt_width(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    grant_e      grant_q, grant_d;
    mem_acc_t    acc_q, acc_d;
    logic        err_q, err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    logic in_acc, cpu_win, dma_win, ack_seen, tmo_hit;
    logic wait_term, tmo_term;

    assign in_acc   = (state_q == ST_CPU_ACC) || (state_q == ST_DMA_ACC);
    assign cpu_win  = (state_q == ST_IDLE) && iCpuReq && !wait_term;
    assign dma_win  = (state_q == ST_IDLE) && !cpu_win && iDmaReq;
    assign ack_seen = in_acc && iMemAck;
    assign tmo_hit  = in_acc && !iMemAck && tmo_term;

    // DMA waits only while someone else owns or wins the port.
    sat_counter #(.LIMIT(STARVE_LIMIT), .WIDTH(WAIT_W)) u_wait_cnt (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .en_i   (iDmaReq && (grant_q != GNT_DMA) && !dma_win),
        .clr_i  (dma_win),
        .term_o (wait_term)
    );

    // Saturates one short of TIMEOUT so the TIMEOUT-th silent cycle is the exit cycle.
    sat_counter #(.LIMIT(TIMEOUT - 1), .WIDTH(TMO_W)) u_tmo_cnt (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .en_i   (in_acc && !iMemAck),
        .clr_i  (!in_acc),
        .term_o (tmo_term)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        acc_d       = acc_q;
        err_d       = err_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (cpu_win) begin
                    state_d = ST_CPU_ACC;
                    grant_d = GNT_CPU;
                    acc_d   = '{we: iCpuWe, addr: iCpuAddr, wdata: iCpuWData, be: iCpuByteEn};
                end else if (dma_win) begin
                    state_d = ST_DMA_ACC;
                    grant_d = GNT_DMA;
                    acc_d   = '{we: iDmaWe, addr: iDmaAddr, wdata: iDmaWData, be: iDmaByteEn};
                end
            end
            ST_CPU_ACC, ST_DMA_ACC: begin
                if (ack_seen || tmo_hit) begin
                    state_d = ST_RESP;
                    err_d   = tmo_hit;
                    // A write has no read data, so its RData register is left alone.
                    if (!acc_q.we) begin
                        if (grant_q == GNT_CPU) begin
                            cpu_rdata_d = ack_seen ? iMemRData : '0;
                        end else begin
                            dma_rdata_d = ack_seen ? iMemRData : '0;
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_NONE;
            acc_q       <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign oMemRead   = in_acc && !acc_q.we;
    assign oMemWrite  = in_acc && acc_q.we;
    assign oMemAddr   = in_acc ? acc_q.addr  : '0;
    assign oMemWData  = in_acc ? acc_q.wdata : '0;
    assign oMemByteEn = in_acc ? acc_q.be    : '0;

    assign oCpuReady = (state_q == ST_RESP) && (grant_q == GNT_CPU);
    assign oDmaReady = (state_q == ST_RESP) && (grant_q == GNT_DMA);
    assign oBusErr   = (state_q == ST_RESP) && err_q;
    assign oGrant    = grant_q;
    assign oCpuRData = cpu_rdata_q;
    assign oDmaRData = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

    localparam int STARVE = 8;
    localparam int TMO    = 255;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iCpuReq = 0, iCpuWe = 0, iDmaReq = 0, iDmaWe = 0, iMemAck = 0;
    logic [31:0] iCpuAddr = 0, iCpuWData = 0, iDmaAddr = 0, iDmaWData = 0, iMemRData = 0;
    logic [3:0]  iCpuByteEn = 0, iDmaByteEn = 0;
    logic        oCpuReady, oDmaReady, oMemRead, oMemWrite, oBusErr;
    logic [31:0] oCpuRData, oDmaRData, oMemAddr, oMemWData;
    logic [3:0]  oMemByteEn;
    logic [1:0]  oGrant;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
        .iCpuByteEn(iCpuByteEn), .oCpuReady(oCpuReady), .oCpuRData(oCpuRData),
        .iDmaReq(iDmaReq), .iDmaWe(iDmaWe), .iDmaAddr(iDmaAddr), .iDmaWData(iDmaWData),
        .iDmaByteEn(iDmaByteEn), .oDmaReady(oDmaReady), .oDmaRData(oDmaRData),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemByteEn(oMemByteEn),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .iMemAck(iMemAck), .iMemRData(iMemRData),
        .oBusErr(oBusErr), .oGrant(oGrant)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting for arbitration, 1 = access on the bus, 2 = completion cycle.
    int          m_phase = 0;
    int          m_who   = 0;      // 0 CPU, 1 DMA
    int          m_age   = 0;
    int          m_wait  = 0;
    logic        m_we    = 0;
    logic        m_err   = 0;
    logic [31:0] m_addr  = 0, m_wdata = 0;
    logic [3:0]  m_be    = 0;
    logic [31:0] m_rd [2];

    task automatic model_step();
        if (iRST) begin
            m_phase = 0; m_who = 0; m_wait = 0; m_err = 0; m_age = 0;
            m_rd[0] = 0; m_rd[1] = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (iCpuReq && m_wait < STARVE) begin
                    m_who = 0; m_we = iCpuWe; m_addr = iCpuAddr; m_wdata = iCpuWData; m_be = iCpuByteEn;
                    m_phase = 1; m_age = 0;
                    if (iDmaReq && m_wait < STARVE) m_wait++;
                end else if (iDmaReq) begin
                    m_who = 1; m_we = iDmaWe; m_addr = iDmaAddr; m_wdata = iDmaWData; m_be = iDmaByteEn;
                    m_phase = 1; m_age = 0; m_wait = 0;
                end
            end
            1: begin
                if (iDmaReq && m_who == 0 && m_wait < STARVE) m_wait++;
                if (iMemAck) begin
                    if (!m_we) m_rd[m_who] = iMemRData;
                    m_err = 0; m_phase = 2;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        if (!m_we) m_rd[m_who] = 0;
                        m_err = 1; m_phase = 2;
                    end
                end
            end
            default: begin
                if (iDmaReq && m_who == 0 && m_wait < STARVE) m_wait++;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic compare();
        logic acc;
        acc = (m_phase == 1);
        chk("grant",     32'(oGrant),     (m_phase == 0) ? 32'd0 : ((m_who == 0) ? 32'd1 : 32'd2));
        chk("mem_read",  32'(oMemRead),   32'(acc && !m_we));
        chk("mem_write", 32'(oMemWrite),  32'(acc && m_we));
        chk("mem_addr",  oMemAddr,        acc ? m_addr : 32'd0);
        chk("mem_wdata", oMemWData,       acc ? m_wdata : 32'd0);
        chk("mem_be",    32'(oMemByteEn), acc ? 32'(m_be) : 32'd0);
        chk("cpu_ready", 32'(oCpuReady),  32'(m_phase == 2 && m_who == 0));
        chk("dma_ready", 32'(oDmaReady),  32'(m_phase == 2 && m_who == 1));
        chk("bus_err",   32'(oBusErr),    32'(m_phase == 2 && m_err));
        chk("cpu_rdata", oCpuRData,       m_rd[0]);
        chk("dma_rdata", oDmaRData,       m_rd[1]);
    endtask

    initial forever begin
        @(posedge iCLK);
        model_step();
        #1;
        compare();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         ngrant;
        logic [7:0] seq;
        logic [1:0] prev_g;

        #1 iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        chk("rst_grant", 32'(oGrant), 32'd0);
        chk("rst_cpu_ready", 32'(oCpuReady), 32'd0);
        chk("rst_cpu_rdata", oCpuRData, 32'd0);
        chk("rst_mem_read", 32'(oMemRead), 32'd0);
        iRST = 1'b0;
        @(negedge iCLK);

        // Lone CPU read with ack one cycle after grant
        iCpuReq = 1; iCpuWe = 0; iCpuAddr = 32'h100; iCpuByteEn = 4'hF; iCpuWData = 0;
        @(negedge iCLK);
        chk("a_grant", 32'(oGrant), 32'd1);
        chk("a_read", 32'(oMemRead), 32'd1);
        chk("a_addr", oMemAddr, 32'h100);
        iMemAck = 1; iMemRData = 32'h12345678;
        @(negedge iCLK);
        chk("a_ready", 32'(oCpuReady), 32'd1);
        chk("a_rdata", oCpuRData, 32'h12345678);
        iMemAck = 0; iCpuReq = 0;
        @(negedge iCLK);
        chk("a_ready_gone", 32'(oCpuReady), 32'd0);
        chk("a_grant_idle", 32'(oGrant), 32'd0);

        // Starvation: CPU continuous, DMA gets every 4th grant
        iCpuReq = 1; iCpuWe = 0; iCpuAddr = 32'h200;
        iDmaReq = 1; iDmaWe = 0; iDmaAddr = 32'h300; iDmaByteEn = 4'hF;
        iMemAck = 1; iMemRData = 32'h5555AAAA;
        ngrant = 0; seq = 0; prev_g = 0;
        for (int c = 0; c < 60 && ngrant < 8; c++) begin
            @(negedge iCLK);
            if (oGrant != 2'b00 && prev_g == 2'b00) begin
                seq = {seq[6:0], oGrant == 2'b10};
                ngrant++;
            end
            prev_g = oGrant;
        end
        chk("b_grants", 32'(ngrant), 32'd8);
        chk("b_sequence", 32'(seq), 32'h11);
        iCpuReq = 0; iDmaReq = 0;
        repeat (4) @(negedge iCLK);
        iMemAck = 0;
        @(negedge iCLK);

        // DMA write held until ack, RData untouched
        iDmaReq = 1; iDmaWe = 1; iDmaAddr = 32'hA0; iDmaWData = 32'hCAFEBABE; iDmaByteEn = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            @(negedge iCLK);
            chk("c_write", 32'(oMemWrite), 32'd1);
            chk("c_wdata", oMemWData, 32'hCAFEBABE);
            chk("c_be", 32'(oMemByteEn), 32'h3);
        end
        iMemAck = 1; iMemRData = 32'hDEADBEEF;
        @(negedge iCLK);
        chk("c_ready", 32'(oDmaReady), 32'd1);
        chk("c_rdata_kept", oDmaRData, 32'h5555AAAA);
        iMemAck = 0; iDmaReq = 0; iDmaWe = 0;
        @(negedge iCLK);

        // CPU read timeout
        iCpuReq = 1; iCpuWe = 0; iCpuAddr = 32'h400;
        k = 301;
        for (int c = 1; c <= 300; c++) begin
            @(negedge iCLK);
            if (oCpuReady) begin
                k = c;
                break;
            end
        end
        chk("d_latency", 32'(k), 32'd256);
        chk("d_buserr", 32'(oBusErr), 32'd1);
        chk("d_rdata", oCpuRData, 32'd0);
        iCpuReq = 0;
        @(negedge iCLK);
        chk("d_idle", 32'(oGrant), 32'd0);

        // Reset in the middle of a DMA access
        iDmaReq = 1; iDmaWe = 0; iDmaAddr = 32'h500;
        @(negedge iCLK);
        chk("e_grant", 32'(oGrant), 32'd2);
        iRST = 1;
        #1;
        chk("e_rst_grant", 32'(oGrant), 32'd0);
        chk("e_rst_read", 32'(oMemRead), 32'd0);
        chk("e_rst_ready", 32'(oDmaReady), 32'd0);
        @(negedge iCLK);
        iRST = 0;
        @(negedge iCLK);
        chk("e_regrant", 32'(oGrant), 32'd2);
        iMemAck = 1; iMemRData = 32'h0BADF00D;
        @(negedge iCLK);
        chk("e_ready", 32'(oDmaReady), 32'd1);
        iMemAck = 0; iDmaReq = 0;
        repeat (2) @(negedge iCLK);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge iCLK);
            if (!iCpuReq || (m_phase == 2 && m_who == 0)) begin
                iCpuReq = ($urandom_range(0, 2) == 0);
                iCpuWe = $urandom_range(0, 1) == 1;
                iCpuAddr = $urandom; iCpuWData = $urandom; iCpuByteEn = 4'($urandom);
            end
            if (!iDmaReq || (m_phase == 2 && m_who == 1)) begin
                iDmaReq = ($urandom_range(0, 1) == 0);
                iDmaWe = $urandom_range(0, 1) == 1;
                iDmaAddr = $urandom; iDmaWData = $urandom; iDmaByteEn = 4'($urandom);
            end
            iMemAck = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            iMemRData = $urandom;
        end
        iCpuReq = 0; iDmaReq = 0; iMemAck = 0;
        repeat (3) @(negedge iCLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: DMA wait-cycle count that overrides CPU priority.
REQ-002 SHALL have parameter TIMEOUT, default 255: cycles without iMemAck before an access is aborted.
REQ-003 SHALL have iCLK input 1: clock; iRST input 1: reset, asynchronous, active-high.
REQ-004 SHALL have iCpuReq/iCpuWe input 1 each: CPU (multicycle control) access request and write strobe.
REQ-005 SHALL have iCpuAddr, iCpuWData input 32 each, and iCpuByteEn input 4: CPU access fields.
REQ-006 SHALL have oCpuReady output 1 and oCpuRData output 32: CPU completion pulse and read data.
REQ-007 SHALL have iDmaReq, iDmaWe, iDmaAddr, iDmaWData, iDmaByteEn, oDmaReady, oDmaRData: same widths and meaning, DMA port.
REQ-008 SHALL have oMemAddr output 32, oMemWData output 32, oMemByteEn output 4, oMemRead output 1, oMemWrite output 1: shared memory port.
REQ-009 SHALL have iMemAck input 1 and iMemRData input 32: memory completion and read data.
REQ-010 SHALL have oBusErr output 1: one-cycle pulse coincident with the Ready of a timed-out access.
REQ-011 SHALL have oGrant output 2: 00 none, 01 CPU, 10 DMA (current owner, for debug/state display).

Function
REQ-012 SHALL implement FSM states IDLE, CPU_ACC, DMA_ACC, RESP.
REQ-013 IDLE: no request -> IDLE; requests sampled only in IDLE.
REQ-014 IDLE arbitration: CPU wins if iCpuReq and DMA wait counter < STARVE_LIMIT; else DMA wins if iDmaReq; winner -> *_ACC.
REQ-015 DMA wait counter SHALL increment each cycle iDmaReq is high and DMA not granted, saturate at STARVE_LIMIT, clear on DMA grant.
REQ-016 *_ACC: oMemRead = ~We, oMemWrite = We, address/data/byte-enable muxed from winner, held stable until exit.
REQ-017 In IDLE and RESP, oMemRead, oMemWrite SHALL be 0; oMemAddr/WData/ByteEn 0.
REQ-018 *_ACC with iMemAck=1 SHALL latch iMemRData into the winner's RData register and go to RESP.
REQ-019 *_ACC SHALL count cycles without ack; on count reaching TIMEOUT SHALL latch RData = 0 and go to RESP flagged as error.
REQ-020 RESP SHALL pulse the winner's Ready for exactly one cycle (plus oBusErr if flagged), then -> IDLE.
REQ-021 Minimum latency: req seen in IDLE at cycle N, ack at N+1 -> Ready at N+2; back-to-back throughput one access per 3 cycles.
REQ-022 RData registers SHALL hold last value until next completion to that port; writes leave RData unchanged.
REQ-023 Requester SHALL hold request fields stable until its Ready; a request dropped mid-access does not abort the access.
REQ-024 iMemAck outside *_ACC SHALL be ignored.
REQ-025 oGrant SHALL be 01 in CPU_ACC and RESP-after-CPU, 10 for DMA, 00 in IDLE.

Reset
REQ-026 iRST SHALL asynchronously force IDLE, all counters 0, oGrant 00, both Ready 0, both RData 0, oBusErr 0, memory strobes 0.
REQ-027 Reset mid-access SHALL abandon the access with no Ready pulse; requests still high after release are re-arbitrated from IDLE.

Structure
REQ-028 State encodings and oGrant codes SHALL live in the shared CPU definitions package alongside control state constants.
REQ-029 The wait/timeout counter pair SHALL be a single sub-module sat_counter (enable, clear, saturate, terminal flag), instantiated twice.

Verification
REQ-030 CPU read alone, ack one cycle after grant -> oCpuReady at cycle 2, oCpuRData = iMemRData value 0x12345678, oGrant 01.
REQ-031 CPU and DMA request same cycle, CPU continuous -> CPU served until DMA waited 8 cycles, then DMA granted; counter clears.
REQ-032 DMA write 0xCAFEBABE, ByteEn 0011 -> oMemWrite=1 with those fields held until ack; oDmaReady pulse; oDmaRData unchanged.
REQ-033 No ack for 255 cycles in CPU_ACC -> oCpuReady and oBusErr pulse together, oCpuRData = 0, FSM returns IDLE.
REQ-034 iRST asserted in DMA_ACC -> outputs immediately reset, no oDmaReady; after release held iDmaReq is granted again.
